// File: rtl/conv_viterbi_decoder.sv
// conv_viterbi_decoder
//   Hard-decision Viterbi decoder for the rate-1/3, K=7 tail-biting
//   convolutional code (generators 133, 171, 165 octal). The tail byte gives
//   the start and end trellis state. The block is a fixed-length ACS pass
//   followed by a traceback from that state. Decoded bits are emitted as bytes,
//   MSB first.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   start              one-cycle pulse in IDLE that begins a block
//   code_block_length  sampled at start: 1 -> N=6144, 0 -> N=1056
//   tail_byte          sampled at start; tail_state = tail_byte[5:0]
//   in_valid, in_bits  hard symbol {d2,d1,d0}, consumed only in ACS
//   out_valid, out_byte  decoded byte stream, earliest bit in out_byte[7]
//   busy               high from the cycle after start until done
//   done               one-cycle pulse after the last byte
//   pm_final           (only with CONV_DEC_PM_REPORT_EN) final metric of the
//                      tail state, i.e. corrected hard errors mod 2^PM_W
//
// Optional feature macro: CONV_DEC_PM_REPORT_EN
module conv_viterbi_decoder #(
  parameter int MAX_N = 6144,
  parameter int PM_W  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       code_block_length,
  input  logic [7:0] tail_byte,
  input  logic       in_valid,
  input  logic [2:0] in_bits,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       busy,
  output logic       done
`ifdef CONV_DEC_PM_REPORT_EN
  ,
  output logic [PM_W-1:0] pm_final
`endif
);

  localparam int AW = $clog2(MAX_N);
  localparam int BW = $clog2(MAX_N / 8);

  // Generator taps indexed by delay: bit i multiplies D^i, where D^0 is the
  // current input bit and D^i (i>0) is state bit s[i-1].
  localparam logic [6:0] G0 = 7'b1101101;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b1010111;

  typedef enum logic [1:0] {ST_IDLE, ST_ACS, ST_TRACE, ST_OUTPUT} state_t;

  function automatic logic [2:0] branch_sym(input logic [5:0] s, input logic c);
    logic [6:0] x;
    x = {s, c};
    return {^(x & G2), ^(x & G1), ^(x & G0)};
  endfunction

  function automatic logic [1:0] ones3(input logic [2:0] a);
    return 2'(a[0]) + 2'(a[1]) + 2'(a[2]);
  endfunction

  state_t                   state_q, state_d;
  logic                     long_q, long_d;
  logic [5:0]               tail_q, tail_d;
  logic [AW-1:0]            k_q, k_d;
  logic                     prime_q, prime_d;
  logic [5:0]               trace_s_q, trace_s_d;
  logic [7:0]               acc_q, acc_d;
  logic [BW-1:0]            j_q, j_d;
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_byte_q, out_byte_d;
  logic                     done_q, done_d;
  logic [63:0][PM_W-1:0]    pm_q, pm_d;
`ifdef CONV_DEC_PM_REPORT_EN
  logic [PM_W-1:0]          pmf_q, pmf_d;
`endif

  logic [63:0][PM_W-1:0]    acs_pm;
  logic [63:0]              acs_dec;
  logic                     surv_we, dec_we;
  logic [AW-1:0]            surv_raddr;
  logic [63:0]              surv_word_q;
  logic [63:0]              surv_mem [MAX_N];
  logic [7:0]               dec_mem [MAX_N / 8];
  logic [AW-1:0]            last_k;
  logic [BW-1:0]            nbytes;
  logic                     unused_tail_bits;

  assign unused_tail_bits = ^tail_byte[7:6];
  assign last_k = long_q ? AW'(MAX_N - 1) : AW'(1055);
  assign nbytes = long_q ? BW'(MAX_N / 8) : BW'(132);

  // Add-compare-select for all 64 states. Predecessors of s' are {b, s'[5:1]};
  // the winner is picked by the sign of the modular metric difference so the
  // metrics may wrap freely. A tie keeps b=0.
  always_comb begin
    logic [5:0]      sp, p0, p1;
    logic [PM_W-1:0] m0, m1, diff;
    acs_pm  = '0;
    acs_dec = '0;
    sp = '0; p0 = '0; p1 = '0;
    m0 = '0; m1 = '0; diff = '0;
    for (int i = 0; i < 64; i++) begin
      sp   = 6'(i);
      p0   = {1'b0, sp[5:1]};
      p1   = {1'b1, sp[5:1]};
      m0   = pm_q[p0] + PM_W'(ones3(branch_sym(p0, sp[0]) ^ in_bits));
      m1   = pm_q[p1] + PM_W'(ones3(branch_sym(p1, sp[0]) ^ in_bits));
      diff = m1 - m0;
      acs_dec[i] = diff[PM_W-1];
      acs_pm[i]  = diff[PM_W-1] ? m1 : m0;
    end
  end

  // The survivor memory has a registered read port, so TRACE spends its first
  // cycle priming the read of word N-1; each later step prefetches word k-1.
  assign surv_raddr = (prime_q || (k_q == '0)) ? k_q : k_q - AW'(1);

  always_comb begin
    state_d     = state_q;
    long_d      = long_q;
    tail_d      = tail_q;
    k_d         = k_q;
    prime_d     = prime_q;
    trace_s_d   = trace_s_q;
    acc_d       = acc_q;
    j_d         = j_q;
    out_valid_d = 1'b0;
    out_byte_d  = out_byte_q;
    done_d      = 1'b0;
    pm_d        = pm_q;
    surv_we     = 1'b0;
    dec_we      = 1'b0;
`ifdef CONV_DEC_PM_REPORT_EN
    pmf_d       = pmf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACS;
          long_d  = code_block_length;
          tail_d  = tail_byte[5:0];
          k_d     = '0;
          for (int i = 0; i < 64; i++)
            pm_d[i] = (6'(i) == tail_byte[5:0]) ? '0 : PM_W'(63);
`ifdef CONV_DEC_PM_REPORT_EN
          pmf_d = '0;
`endif
        end
      end
      ST_ACS: begin
        if (in_valid) begin
          pm_d    = acs_pm;
          surv_we = 1'b1;
          if (k_q == last_k) begin
            state_d   = ST_TRACE;
            prime_d   = 1'b1;
            trace_s_d = tail_q;
`ifdef CONV_DEC_PM_REPORT_EN
            pmf_d = acs_pm[tail_q];
`endif
          end else begin
            k_d = k_q + AW'(1);
          end
        end
      end
      ST_TRACE: begin
        if (prime_q) begin
          prime_d = 1'b0;
        end else begin
          // Bits arrive newest first, so shifting in at the MSB leaves bit 8j
          // in position 7 once k reaches a byte boundary.
          acc_d     = {trace_s_q[0], acc_q[7:1]};
          trace_s_d = {surv_word_q[trace_s_q], trace_s_q[5:1]};
          dec_we    = (k_q[2:0] == 3'd0);
          if (k_q == '0) begin
            state_d = ST_OUTPUT;
            j_d     = '0;
          end else begin
            k_d = k_q - AW'(1);
          end
        end
      end
      ST_OUTPUT: begin
        if (j_q == nbytes) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_byte_d  = dec_mem[j_q];
          j_d         = j_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      long_q      <= 1'b0;
      tail_q      <= '0;
      k_q         <= '0;
      prime_q     <= 1'b0;
      trace_s_q   <= '0;
      acc_q       <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      done_q      <= 1'b0;
      pm_q        <= '0;
`ifdef CONV_DEC_PM_REPORT_EN
      pmf_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      long_q      <= long_d;
      tail_q      <= tail_d;
      k_q         <= k_d;
      prime_q     <= prime_d;
      trace_s_q   <= trace_s_d;
      acc_q       <= acc_d;
      j_q         <= j_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      done_q      <= done_d;
      pm_q        <= pm_d;
`ifdef CONV_DEC_PM_REPORT_EN
      pmf_q       <= pmf_d;
`endif
    end
  end

  // Storage arrays carry no reset; every location is written before it is read
  // within a block.
  always_ff @(posedge clk) begin
    if (surv_we) surv_mem[k_q] <= acs_dec;
    if (dec_we) dec_mem[k_q[AW-1:3]] <= acc_d;
    if (state_q == ST_TRACE) surv_word_q <= surv_mem[surv_raddr];
  end

  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef CONV_DEC_PM_REPORT_EN
  assign pm_final  = pmf_q;
`endif

endmodule

// File: tb/tb_conv_viterbi_decoder.sv
// Directed testbench for conv_viterbi_decoder: encodes known byte patterns with
// an independent encoder model, feeds the symbols and checks decoded bytes,
// output timing, control strobes and reset behaviour.
module tb_conv_viterbi_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       code_block_length = 1'b0;
  logic [7:0] tail_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic [2:0] in_bits = 3'b000;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       busy;
  logic       done;
`ifdef CONV_DEC_PM_REPORT_EN
  logic [7:0] pm_final;
`endif

  int compared = 0;
  int mismatched = 0;

  logic       msg [6144];
  logic [2:0] sym [6144];
  logic [7:0] pattern [12] = '{8'hA6, 8'hB7, 8'hF3, 8'hAF, 8'hB2, 8'h0D,
                               8'h9C, 8'hFF, 8'hA7, 8'h88, 8'h69, 8'h5A};

  conv_viterbi_decoder dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .code_block_length (code_block_length),
    .tail_byte         (tail_byte),
    .in_valid          (in_valid),
    .in_bits           (in_bits),
    .out_valid         (out_valid),
    .out_byte          (out_byte),
    .busy              (busy),
    .done              (done)
`ifdef CONV_DEC_PM_REPORT_EN
    ,
    .pm_final          (pm_final)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Generators written MSB-first as octal: leftmost bit is the D^0 tap.
  function automatic logic [2:0] encodeBit(input logic [5:0] st, input logic c);
    logic [6:0] gen [3];
    logic [6:0] r;
    logic [2:0] d;
    gen[0] = 7'o133;
    gen[1] = 7'o171;
    gen[2] = 7'o165;
    r = {st, c};
    d = 3'b000;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 7; i++)
        d[j] = d[j] ^ (r[i] & gen[j][6-i]);
    return d;
  endfunction

  task automatic buildBlock(input int nbits, input logic [7:0] tail, input bit useZero, input int errStep);
    logic [5:0] st;
    int idx;
    st = tail[5:0];
    for (int k = 0; k < nbits; k++)
      msg[k] = useZero ? 1'b0 : pattern[(k / 8) % 12][7 - (k % 8)];
    for (int k = 0; k < nbits; k++) begin
      sym[k] = encodeBit(st, msg[k]);
      st = {st[4:0], msg[k]};
      if (errStep > 0 && (k % errStep) == 0) begin
        idx = (k / errStep) % 3;
        sym[k][idx] = ~sym[k][idx];
      end
    end
  endtask

  task automatic applyStimulus(input bit lng, input logic [7:0] tail, input bit useZero,
                               input int errStep, input bit stall, input bit midStart,
                               input int abortAt, input int expPm);
    int nbits, nbytes, k, cyc, edges;
    logic [7:0] expByte;
    nbits  = lng ? 6144 : 1056;
    nbytes = nbits / 8;
    buildBlock(nbits, tail, useZero, errStep);
    $display("[TB] block N=%0d tail=%0h errStep=%0d stall=%0d expected metric %0d",
             nbits, tail, errStep, stall, expPm);

    // Start together with a bogus valid symbol: the symbol must be dropped.
    @(posedge clk); #1;
    start = 1'b1; code_block_length = lng; tail_byte = tail;
    in_valid = 1'b1; in_bits = ~sym[0];
    @(posedge clk); #1;
    start = 1'b0; code_block_length = ~lng; tail_byte = ~tail; in_valid = 1'b0;
    checkOutput("busy_rise", busy, 1);

    k = 0; cyc = 0;
    while (k < nbits) begin
      in_valid = !(stall && (cyc % 2 == 1));
      in_bits  = in_valid ? sym[k] : ~sym[k];
      start    = midStart && (k == 300);
      @(posedge clk); #1;
      if (in_valid) k++;
      cyc++;
      if (abortAt >= 0 && k == abortAt) begin
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_out_byte", out_byte, 0);
        in_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
    end
    in_valid = 1'b0; start = 1'b0;

    edges = 0;
    while (out_valid !== 1'b1 && edges < nbits + 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("first_out_latency", edges, nbits + 2);

    for (int j = 0; j < nbytes; j++) begin
      expByte = useZero ? 8'h00 : pattern[j % 12];
      checkOutput("out_valid_run", out_valid, 1);
      checkOutput($sformatf("byte%0d", j), out_byte, expByte);
      @(posedge clk); #1;
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("busy_fall", busy, 0);
    checkOutput("out_valid_end", out_valid, 0);
`ifdef CONV_DEC_PM_REPORT_EN
    checkOutput("pm_final", pm_final, expPm);
`endif
    @(posedge clk); #1;
    checkOutput("done_low", done, 0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_out_byte", out_byte, 0);
`ifdef CONV_DEC_PM_REPORT_EN
    checkOutput("reset_pm_final", pm_final, 0);
`endif
    reset = 1'b0;

    // Valid symbols in IDLE are ignored.
    in_valid = 1'b1; in_bits = 3'b101;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_out_valid", out_valid, 0);
    in_valid = 1'b0;

    applyStimulus(1'b0, 8'h00, 1'b1, 0,  1'b0, 1'b0, -1, 0);
    applyStimulus(1'b0, 8'h5A, 1'b0, 0,  1'b0, 1'b0, -1, 0);
    applyStimulus(1'b0, 8'h5A, 1'b0, 40, 1'b0, 1'b0, -1, 27);
    applyStimulus(1'b1, 8'h5A, 1'b0, 0,  1'b0, 1'b0, -1, 0);
    applyStimulus(1'b0, 8'h5A, 1'b0, 0,  1'b1, 1'b1, -1, 0);
    applyStimulus(1'b0, 8'h5A, 1'b0, 0,  1'b0, 1'b0, 500, 0);
    applyStimulus(1'b0, 8'h5A, 1'b0, 0,  1'b0, 1'b0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/conv_viterbi_decoder.md
# conv_viterbi_decoder

Hard-decision Viterbi decoder for the rate-1/3, K=7 tail-biting convolutional code produced by the encoder path (generators 133, 171, 165 octal). It sits on the receive side and consumes one 3-bit hard symbol (d0, d1, d2) per accepted cycle. The block length is selected by `code_block_length`: 6144 or 1056 bits. The known tail byte supplies the start and end trellis state, so decoding is a fixed-length Viterbi pass with traceback from that state. Decoded bits are emitted as bytes, MSB first.

## Interface
- MAX_N, 6144: survivor and decoded-bit memory depth in bits.
- PM_W, 8: path-metric width; metrics use modular arithmetic.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse in IDLE that begins a block.
- code_block_length  in  1  sampled at start: 1 gives N=6144, 0 gives N=1056.
- tail_byte  in  8  sampled at start; tail_state = tail_byte[5:0].
- in_valid  in  1  qualifies in_bits.
- in_bits  in  3  hard symbol {d2,d1,d0}.
- out_valid  out  1  out_byte valid this cycle.
- out_byte  out  8  decoded byte; earliest bit is in [7].
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last byte.

## Operation
- State encoding: s[0] = most recent input bit c(k-1), s[5] = c(k-6). Next state is {s[4:0], c}.
- Branch outputs for input bit c in state s: d_j = parity of taps g_j over {c, s[0..5]}.
  - g0 = 1011011.
  - g1 = 1111001.
  - g2 = 1110101.
  - Tap order is D^0..D^6.
- FSM: IDLE -> ACS -> TRACE -> OUTPUT -> IDLE.
- IDLE to ACS on start:
  - latch N and tail_state;
  - set PM[tail_state] = 0 and all other PM = 63.
- ACS: each cycle with in_valid high consumes one symbol.
  - Branch metric is the Hamming distance, 0..3.
  - For each s', predecessors are {b, s'[5:1]} with b in {0,1}. Compare PM + BM for both.
  - Compare with modular signed difference (MSB of the PM_W-bit subtraction).
  - Ties select b=0.
  - Store the 64-bit survivor word (chosen b per state) at address k.
  - After N symbols, go to TRACE.
- TRACE: start at state tail_state, time N-1. One step per cycle:
  - decoded bit[k] = s[0];
  - s = {surv[k][s], s[5:1]};
  - k decrements.
  - After N steps, go to OUTPUT.
- OUTPUT: N/8 consecutive cycles of out_valid. Byte j = bits 8j..8j+7, with bit 8j in out_byte[7]. Then done pulses and the FSM returns to IDLE.
- Input handling:
  - in_valid is ignored outside ACS.
  - start is ignored while busy.
  - in_valid gaps in ACS stall the trellis with no state change.
- Simultaneous start and in_valid in IDLE: start is taken and the symbol is dropped.

## Timing
- Reset values:
  - FSM = IDLE;
  - out_valid = 0, out_byte = 0, busy = 0, done = 0;
  - all PM = 0;
  - pm_final = 0 when present.
- Memory contents are not reset.
- busy rises on the edge that samples start.
- One symbol is accepted per edge with in_valid high in ACS.
- The first out_valid is exactly N+2 edges after the edge that accepts the last symbol.
- out_valid stays contiguous for N/8 cycles.
- done is high on the cycle after the last out_valid. busy falls on that same edge.
- Reset asserted at any point aborts the block immediately. The next start decodes normally.

## Configuration
- CONV_DEC_PM_REPORT_EN defined:
  - adds output pm_final [PM_W-1:0];
  - pm_final = PM[tail_state] latched on the ACS-to-TRACE transition, equal to the corrected hard errors mod 2^PM_W;
  - pm_final holds until the next start.
- CONV_DEC_PM_REPORT_EN undefined: the port and its register are absent. Decoding behaviour is identical.

## Test plan
- All-zero data: tail_byte=00, N=1056, all symbols 000 -> 132 bytes of 00, done at the specified cycle, pm_final=0.
- Repeating data: bytes A6 B7 F3 AF B2 0D 9C FF A7 88 69 5A repeated to 132 bytes, tail_byte=5A, encoded by the bench model, error-free -> identical 132 bytes, pm_final=0.
- Injected errors: same stream with one bit flipped at symbols 0, 40, …, 1040 -> identical bytes, pm_final=27.
- Long block: code_block_length=1, same pattern to 768 bytes, tail_byte=5A -> 768 correct bytes; first out_valid 6146 edges after the last symbol.
- Stalls and ignored start: in_valid toggled every other cycle, plus a start pulse mid-block -> output unchanged, second start ignored.
- Reset mid-block: reset during ACS at symbol 500 -> all outputs 0 immediately; a following clean 1056-bit block decodes exactly.
